// File: rtl/data_memory_dumper.sv
// data_memory_dumper: walks debug addresses 0..N-1 of the data memory and
// streams each word MSB byte first to the UART TX over valid/ready.
// Ports: i_clk, i_rst (sync, active-high), i_start/i_num_words request,
// o_addr_debug/o_mem_run/i_data_debug memory debug port,
// o_tx_data/o_tx_valid/i_tx_ready TX handshake, o_busy/o_done status.
// Option: define DUMP_CHECKSUM_EN to append an XOR checksum byte.
module data_memory_dumper #(
  parameter int NB_DEPTH = 8,
  parameter int NB_DATA  = 32,
  parameter int NB_BYTE  = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [NB_DEPTH:0]   i_num_words,
  output logic [NB_DEPTH-1:0] o_addr_debug,
  output logic                o_mem_run,
  input  logic [NB_DATA-1:0]  i_data_debug,
  output logic [NB_BYTE-1:0]  o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic                o_busy,
  output logic                o_done
);

  localparam int NB_WBYTES = NB_DATA / NB_BYTE;
  localparam int NB_BIDX   = (NB_WBYTES > 1) ? $clog2(NB_WBYTES) : 1;
  localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(NB_WBYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    LOAD,
    SEND,
    NEXT,
`ifdef DUMP_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

  state_t                state_q;
  logic [NB_DEPTH:0]     cnt_q;
  logic [NB_DEPTH:0]     idx_q;
  logic [NB_BIDX-1:0]    bidx_q;
  logic [NB_DATA-1:0]    shift_q;
  logic [NB_DEPTH-1:0]   addr_q;
  logic                  run_q;
  logic [NB_BYTE-1:0]    txd_q;
  logic                  txv_q;
  logic                  busy_q;
  logic                  done_q;
`ifdef DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0]    csum_q;
`endif

  // Index is one bit wider than the address so a full-depth dump
  // reaches the count compare without wrapping.
  logic [NB_DEPTH:0]     idx_d;
  logic [NB_DATA-1:0]    shift_d;
  logic                  accept;

  assign idx_d   = idx_q + 1'b1;
  assign shift_d = shift_q << NB_BYTE;
  assign accept  = txv_q & i_tx_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      run_q   <= 1'b1;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            busy_q <= 1'b1;
            idx_q  <= '0;
            cnt_q  <= i_num_words;
`ifdef DUMP_CHECKSUM_EN
            csum_q <= '0;
`endif
            if (i_num_words != '0) begin
              addr_q  <= '0;
              run_q   <= 1'b0;
              state_q <= ADDR;
            end else begin
`ifdef DUMP_CHECKSUM_EN
              txd_q   <= '0;
              txv_q   <= 1'b1;
              state_q <= CSUM;
`else
              done_q  <= 1'b1;
              state_q <= DONE;
`endif
            end
          end
        end
        ADDR: state_q <= WAIT;
        WAIT: state_q <= LOAD;
        LOAD: begin
          shift_q <= i_data_debug;
          bidx_q  <= '0;
          txd_q   <= i_data_debug[NB_DATA-1 -: NB_BYTE];
          txv_q   <= 1'b1;
          state_q <= SEND;
        end
        SEND: begin
          if (accept) begin
`ifdef DUMP_CHECKSUM_EN
            csum_q <= csum_q ^ txd_q;
`endif
            if (bidx_q == LAST_BYTE) begin
              txv_q   <= 1'b0;
              state_q <= NEXT;
            end else begin
              bidx_q  <= bidx_q + 1'b1;
              shift_q <= shift_d;
              txd_q   <= shift_d[NB_DATA-1 -: NB_BYTE];
            end
          end
        end
        NEXT: begin
          if (idx_d == cnt_q) begin
            run_q  <= 1'b1;
            addr_q <= '0;
`ifdef DUMP_CHECKSUM_EN
            txd_q   <= csum_q;
            txv_q   <= 1'b1;
            state_q <= CSUM;
`else
            done_q  <= 1'b1;
            state_q <= DONE;
`endif
          end else begin
            idx_q   <= idx_d;
            addr_q  <= idx_d[NB_DEPTH-1:0];
            state_q <= ADDR;
          end
        end
`ifdef DUMP_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            txv_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
`endif
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_addr_debug = addr_q;
  assign o_mem_run    = run_q;
  assign o_tx_data    = txd_q;
  assign o_tx_valid   = txv_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule
